// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - VRAM read port between scanout engine and frame memory
interface vga_scanout_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] addr;
   logic                  rd_en;
   logic [15:0]           q;

   modport master (output addr, output rd_en, input q);
   modport slave  (input addr, input rd_en, output q);
endinterface

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing generator and VRAM scanout, direct 12-bit or 1bpp mono
module vga_scanout #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] base,
   input  logic [11:0]           fg,
   input  logic [11:0]           bg,
   vga_scanout_if.master         vram,
   output logic [3:0]            VGA_R,
   output logic [3:0]            VGA_G,
   output logic [3:0]            VGA_B,
   output logic                  VGA_HS,
   output logic                  VGA_VS,
   output logic                  vblank,
   output logic                  frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   logic [HW-1:0]         hcount;
   logic [VW-1:0]         vcount;
   logic                  mode_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] line_off;
   logic [ADDR_WIDTH-1:0] line_ptr;
   logic [ADDR_WIDTH-1:0] step;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  h_last, v_last, active, hs_raw, vs_raw, rd_req;

   logic       s1_active, s1_hs, s1_vs, s1_vb, s1_fs, s1_mode;
   logic [3:0] s1_pix;
   logic       s2_active, s2_hs, s2_vs, s2_vb, s2_fs, s2_mode;
   logic [3:0] s2_pix;
   logic [15:0] mono_word;
   logic        mono_bit;
   logic [11:0] pixel;

   assign h_last = (hcount == HW'(H_TOTAL - 1));
   assign v_last = (vcount == VW'(V_TOTAL - 1));
   assign active = (int'(hcount) < H_ACTIVE) && (int'(vcount) < V_ACTIVE);
   assign hs_raw = !((int'(hcount) >= H_ACTIVE + H_FP) && (int'(hcount) < H_ACTIVE + H_FP + H_SYNC));
   assign vs_raw = !((int'(vcount) >= V_ACTIVE + V_FP) && (int'(vcount) < V_ACTIVE + V_FP + V_SYNC));

   // line_ptr is kept as base_q plus a per-frame offset so a base change only lands at frame wrap
   assign line_ptr = base_q + line_off;
   assign step     = mode_q ? ADDR_WIDTH'(H_ACTIVE / 16) : ADDR_WIDTH'(H_ACTIVE);
   assign rd_req   = active && (!mode_q || (hcount[3:0] == 4'd0));
   assign rd_addr  = line_ptr + (mode_q ? ADDR_WIDTH'(hcount >> 4) : ADDR_WIDTH'(hcount));

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         hcount   <= '0;
         vcount   <= '0;
         mode_q   <= 1'b0;
         base_q   <= '0;
         line_off <= '0;
      end else if (h_last) begin
         hcount <= '0;
         if (v_last) begin
            vcount   <= '0;
            mode_q   <= mode;
            base_q   <= base;
            line_off <= '0;
         end else begin
            vcount <= vcount + 1'b1;
            if (int'(vcount) < V_ACTIVE) line_off <= line_off + step;
         end
      end else begin
         hcount <= hcount + 1'b1;
      end
   end

   // Stage 1: VRAM request plus the position attributes that travel alongside it
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         vram.addr  <= '0;
         vram.rd_en <= 1'b0;
         s1_active  <= 1'b0;
         s1_hs      <= 1'b1;
         s1_vs      <= 1'b1;
         s1_vb      <= 1'b0;
         s1_fs      <= 1'b0;
         s1_mode    <= 1'b0;
         s1_pix     <= 4'd0;
      end else begin
         vram.rd_en <= rd_req;
         if (rd_req) vram.addr <= rd_addr;
         s1_active <= active;
         s1_hs     <= hs_raw;
         s1_vs     <= vs_raw;
         s1_vb     <= (int'(vcount) >= V_ACTIVE);
         s1_fs     <= (hcount == '0) && (vcount == '0);
         s1_mode   <= mode_q;
         s1_pix    <= hcount[3:0];
      end
   end

   // Stage 2: attributes wait here while the RAM returns q
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         s2_active <= 1'b0;
         s2_hs     <= 1'b1;
         s2_vs     <= 1'b1;
         s2_vb     <= 1'b0;
         s2_fs     <= 1'b0;
         s2_mode   <= 1'b0;
         s2_pix    <= 4'd0;
      end else begin
         s2_active <= s1_active;
         s2_hs     <= s1_hs;
         s2_vs     <= s1_vs;
         s2_vb     <= s1_vb;
         s2_fs     <= s1_fs;
         s2_mode   <= s1_mode;
         s2_pix    <= s1_pix;
      end
   end

   // q is only fresh on the first pixel of a mono word; later pixels come from the captured copy
   always_comb begin
      pixel    = 12'h000;
      mono_bit = (s2_pix == 4'd0) ? vram.q[15] : mono_word[4'd15 - s2_pix];
      if (s2_active) pixel = s2_mode ? (mono_bit ? fg : bg) : vram.q[11:0];
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         {VGA_R, VGA_G, VGA_B} <= 12'h000;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         vblank      <= 1'b0;
         frame_start <= 1'b0;
         mono_word   <= 16'h0000;
      end else begin
         {VGA_R, VGA_G, VGA_B} <= pixel;
         VGA_HS      <= s2_hs;
         VGA_VS      <= s2_vs;
         vblank      <= s2_vb;
         frame_start <= s2_fs && s2_active;
         if (s2_pix == 4'd0) mono_word <= vram.q;
      end
   end
endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - self-checking bench for vga_scanout with a frame-position reference model
module tb_vga_scanout;
   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        mode;
   logic [15:0] base;
   logic [11:0] fg, bg;
   logic [3:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_HS, VGA_VS, vblank, frame_start;
   logic [15:0] vid;
   logic [15:0] mem [0:65535];

   int checks = 0;
   int failures = 0;
   bit check_en = 1'b0;

   vga_scanout_if #(.ADDR_WIDTH(16)) vram ();

   vga_scanout #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .ADDR_WIDTH(16)
   ) dut (
      .clock(clock), .clear(clear), .mode(mode), .base(base),
      .fg(fg), .bg(bg), .vram(vram),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .vblank(vblank), .frame_start(frame_start)
   );

   initial forever #5 clock = ~clock;

   always @(posedge clock) if (vram.rd_en) vram.q <= mem[vram.addr];

   assign vid = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, vblank, frame_start};

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Reference model: n = edges since reset release; edge n processes raster position n
   int          n = 0;
   logic [15:0] exp_addr = 16'h0000;
   logic        exp_rd = 1'b0;
   logic        fm [0:7] = '{default: 1'b0};
   logic [15:0] fb [0:7] = '{default: 16'h0000};
   logic [15:0] exp_out [0:1023];
   int          mh, mv, mf;
   logic        m_act, m_mono;
   logic [15:0] m_base, m_word;
   logic [11:0] m_pix;

   always @(posedge clock or negedge clear) begin
      if (!clear) begin
         n = 0; exp_addr = 16'h0000; exp_rd = 1'b0; fm[0] = 1'b0; fb[0] = 16'h0000;
      end else begin
         mh = n % 22; mv = (n / 22) % 5; mf = (n / 110) % 8;
         m_mono = fm[mf]; m_base = fb[mf];
         m_act  = (mh < 16) && (mv < 2);
         exp_rd = m_act && (!m_mono || (mh % 16 == 0));
         if (exp_rd) exp_addr = m_base + 16'(m_mono ? mv + mh / 16 : mv * 16 + mh);
         m_pix = 12'h000;
         if (m_act) begin
            if (m_mono) begin
               m_word = mem[16'(m_base + 16'(mv))];
               m_pix  = m_word[15 - mh] ? fg : bg;
            end else begin
               m_pix = mem[exp_addr][11:0];
            end
         end
         if (n < 1024) exp_out[n] = {m_pix, !(mh >= 18 && mh < 20), mv != 3, mv >= 2, mh == 0 && mv == 0};
         if (mh == 21 && mv == 4) begin
            fm[(mf + 1) % 8] = mode;
            fb[(mf + 1) % 8] = base;
         end
         n++;
      end
   end

   always @(negedge clock) begin
      if (check_en) begin
         if (!clear) begin
            chk("reset_outputs", {vid, vram.rd_en, vram.addr}, {16'h000C, 1'b0, 16'h0000});
         end else begin
            chk("rd_addr", {vram.rd_en, vram.addr}, {exp_rd, exp_addr});
            if (n >= 3 && n - 3 < 1024) chk("video", vid, exp_out[n - 3]);
            else if (n < 3) chk("video_flush", vid, 16'h000C);
         end
      end
   end

   int e, hs_lows, vs_lows, fs_cnt, first_hs, first_vs, first_fs, second_fs;

   task automatic clear_stats();
      hs_lows = 0; vs_lows = 0; fs_cnt = 0;
      first_hs = -1; first_vs = -1; first_fs = -1; second_fs = -1;
   endtask

   task automatic gather(input int edge_idx);
      if (!VGA_HS) begin hs_lows++; if (first_hs < 0) first_hs = edge_idx; end
      if (!VGA_VS) begin vs_lows++; if (first_vs < 0) first_vs = edge_idx; end
      if (frame_start) begin
         fs_cnt++;
         if (first_fs < 0) first_fs = edge_idx;
         else if (second_fs < 0) second_fs = edge_idx;
      end
   endtask

   task automatic timing_checks();
      chk("hs_first_low", 40'(first_hs), 40'd20);
      chk("hs_low_count", 40'(hs_lows), 40'd10);
      chk("vs_first_low", 40'(first_vs), 40'd68);
      chk("vs_low_count", 40'(vs_lows), 40'd22);
      chk("fs_first", 40'(first_fs), 40'd2);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'(16'h0ABC + i);
      mem[16'h0100] = 16'h8001;
      mem[16'h0101] = 16'h7FFE;
      mode = 1'b0; base = 16'h0000; fg = 12'h000; bg = 12'h000;
      repeat (3) @(negedge clock);
      check_en = 1'b1;
      #1;
      chk("reset_state", {vid, vram.rd_en, vram.addr}, {16'h000C, 1'b0, 16'h0000});
      @(negedge clock);
      clear = 1'b1;
      clear_stats();
      for (int i = 0; i < 227; i++) begin
         @(negedge clock);
         e = n - 1;
         if (e < 110 || e == 222) gather(e);
         if (e == 109) timing_checks();
         case (e)
            2:   chk("direct_pix0", {vid[15:4], vid[0]}, {12'hABC, 1'b1});
            15:  chk("line0_last_addr", {vram.rd_en, vram.addr}, {1'b1, 16'd15});
            16:  chk("hblank_rd_off", 40'(vram.rd_en), 40'd0);
            22:  chk("line1_first_addr", 40'(vram.addr), 40'd16);
            37:  chk("line1_last_addr", 40'(vram.addr), 40'd31);
            50:  begin mode = 1'b1; base = 16'h0100; fg = 12'hF00; bg = 12'h00F; end
            110: chk("mono_addr", {vram.rd_en, vram.addr}, {1'b1, 16'h0100});
            112: chk("mono_pix0", {vid[15:4], vid[0]}, {12'hF00, 1'b1});
            113: chk("mono_pix1", 40'(vid[15:4]), 40'h00F);
            126: chk("mono_pix14", 40'(vid[15:4]), 40'h00F);
            127: chk("mono_pix15", 40'(vid[15:4]), 40'hF00);
            131: begin base = 16'hFFFF; mode = 1'b0; end
            132: chk("mono_line1_addr", {vram.rd_en, vram.addr}, {1'b1, 16'h0101});
            134: chk("mono_line1_pix0", 40'(vid[15:4]), 40'h00F);
            220: chk("wrap_addr0", 40'(vram.addr), 40'hFFFF);
            221: chk("wrap_addr1", 40'(vram.addr), 40'h0000);
            222: begin
               chk("wrap_addr2", 40'(vram.addr), 40'h0001);
               chk("wrap_pix0", 40'(vid[15:4]), 40'hABB);
               chk("fs_period", 40'(second_fs), 40'd222);
               chk("fs_count", 40'(fs_cnt), 40'd2);
            end
            default: ;
         endcase
      end
      #2 clear = 1'b0;
      #1 chk("async_reset", {vid, vram.rd_en, vram.addr}, {16'h000C, 1'b0, 16'h0000});
      repeat (3) @(negedge clock);
      clear = 1'b1;
      clear_stats();
      for (int i = 0; i < 110; i++) begin
         @(negedge clock);
         e = n - 1;
         gather(e);
         if (e == 0) chk("restart_addr", {vram.rd_en, vram.addr}, {1'b1, 16'h0000});
      end
      timing_checks();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line (multiple of 16).
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, vertical porch and sync widths in lines.
REQ-004 SHALL have parameter ADDR_WIDTH, default 16, VRAM word-address width.
REQ-005 SHALL have ports clock in 1, pixel clock; clear in 1, reset. One clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports mode in 1, 0 = direct 12-bit colour, 1 = 1bpp mono; base in ADDR_WIDTH, frame start word address.
REQ-007 SHALL have ports fg in 12 and bg in 12, mono foreground and background colours {R,G,B}.
REQ-008 SHALL have ports addr out ADDR_WIDTH and rd_en out 1, VRAM read request; q in 16, VRAM data valid exactly 1 clock after the rd_en cycle.
REQ-009 SHALL have ports VGA_R, VGA_G, VGA_B out 4 each; VGA_HS, VGA_VS out 1, active-low; vblank out 1; frame_start out 1.

Function
REQ-010 SHALL keep hcount 0..H_TOTAL-1 (H_TOTAL = sum of H_*), advancing every clock and wrapping to 0.
REQ-011 SHALL keep vcount 0..V_TOTAL-1, advancing when hcount wraps and wrapping to 0 after V_TOTAL-1.
REQ-012 SHALL define active = (hcount < H_ACTIVE) and (vcount < V_ACTIVE).
REQ-013 SHALL assert raw hsync low for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
REQ-014 SHALL assert raw vsync low for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC.
REQ-015 SHALL latch mode and base into mode_q and base_q only at (hcount, vcount) = (H_TOTAL-1, V_TOTAL-1); changes mid-frame SHALL NOT affect the current frame.
REQ-016 SHALL hold line_ptr: set to base_q at frame wrap; after each active line, advance by H_ACTIVE (direct) or H_ACTIVE/16 (mono), modulo 2^ADDR_WIDTH.
REQ-017 Direct mode SHALL assert rd_en on every active cycle, with addr = line_ptr + hcount.
REQ-018 Mono mode SHALL assert rd_en only on active cycles with hcount%16 == 0, with addr = line_ptr + hcount/16.
REQ-019 SHALL hold addr at its last value and rd_en low outside those cycles.
REQ-020 All outputs SHALL be registered with exactly 2 clocks of latency from the counter state they represent; HS, VS, vblank and RGB SHALL stay mutually aligned.
REQ-021 Direct mode pixel SHALL be {R,G,B} = q[11:8], q[7:4], q[3:0]; q[15:12] ignored.
REQ-022 Mono mode pixel SHALL come from q, MSB first, for 16 consecutive pixels: bit 1 -> fg, bit 0 -> bg.
REQ-023 RGB SHALL be 0 whenever the represented position is not active.
REQ-024 vblank SHALL be 1 when the represented vcount >= V_ACTIVE.
REQ-025 frame_start SHALL be a 1-clock pulse coincident with output of pixel (0,0).

Reset
REQ-026 While clear = 0: hcount = vcount = 0, line_ptr = base_q = 0, mode_q = 0.
REQ-027 While clear = 0: addr = 0, rd_en = 0, RGB = 0, VGA_HS = VGA_VS = 1, vblank = 0, frame_start = 0, pipeline flushed.
REQ-028 After clear deasserts, the first clock edge SHALL process position (0,0); the first frame SHALL use base 0 and direct mode.
REQ-029 Reset asserted mid-frame SHALL take effect immediately and asynchronously; no partial line SHALL resume.

Verification
Bench parameters for all scenarios: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1 (H_TOTAL 22, V_TOTAL 5).
REQ-030 Timing: release reset, count clocks -> VGA_HS low for 2 of every 22 clocks, starting 20 clocks after reset release (18+2 latency); VGA_VS low for line 3 of every 5; period 110 clocks.
REQ-031 Direct mode: RAM word n = 0x0ABC+n -> first active pixel R=A, G=B, B=C; addr runs 0..15 on line 0 and 16..31 on line 1; rd_en low in blanking.
REQ-032 Mono mode: base=0x0100 set during frame 0, mode=1, word 0x0100 = 0x8001, fg=0xF00, bg=0x00F -> frame 1 pixel 0 red, pixels 1-14 blue, pixel 15 red; line 1 reads addr 0x0101.
REQ-033 Base change mid-frame: base changed at vcount=1 -> current frame addresses unchanged; the new base is first seen at frame start; frame_start pulses once per 110 clocks.
REQ-034 Wrap: base=0xFFFF in direct mode -> addr sequence 0xFFFF, 0x0000, 0x0001, ...
REQ-035 Reset mid-line: clear low at hcount=7 for 3 clocks -> all outputs at reset values during clear; after release, addr=0 and the timing of REQ-030 restarts.
